// File: rtl/prbs_checker_pkg.sv
// Shared PRBS7 definitions (x^7 + x^6 + 1) for the TX generator and the RX checker.
package prbs_checker_pkg;

  localparam int PRBS_N = 7;
  localparam int TAP_HI = PRBS_N - 1;
  localparam int TAP_LO = PRBS_N - 2;

  typedef logic [PRBS_N-1:0] prbs_t;

  typedef enum logic [1:0] {CHK_SEED, CHK_VERIFY, CHK_LOCKED} CHK_STATE;

  // Next output bit of the generator for the given LFSR contents.
  function automatic logic prbs_pred(input prbs_t s);
    return s[TAP_HI] ^ s[TAP_LO];
  endfunction

  // Left shift with the feedback bit inserted at the LSB.
  function automatic prbs_t prbs_next(input prbs_t s);
    return {s[PRBS_N-2:0], prbs_pred(s)};
  endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Bit-stream and status bundle between the RX datapath (master) and the checker (slave).
interface prbs_checker_if #(
  parameter int BIT_WIDTH = 48,
  parameter int ERR_WIDTH = 32
);
  logic                 cke;
  logic                 in;
  logic                 clear;
  logic                 locked;
  logic                 err;
  logic [BIT_WIDTH-1:0] bit_count;
  logic [ERR_WIDTH-1:0] err_count;

  modport master (output cke, in, clear, input locked, err, bit_count, err_count);
  modport slave  (input cke, in, clear, output locked, err, bit_count, err_count);
endinterface

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear first, then increment unless already at all-ones.
  always_comb begin
    // NOTE: default assignment up front so no path leaves count_d unassigned (no latch).
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !(&count_q)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/prbs_checker.sv
// PRBS7 receive checker: self-seeds an LFSR from the incoming stream, verifies it,
// then tracks lock, per-bit errors and saturating bit/error counts for BER probing.
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int LOCK_COUNT  = 64,
  parameter int WINDOW      = 256,
  parameter int UNLOCK_ERRS = 16,
  parameter int BIT_WIDTH   = 48,
  parameter int ERR_WIDTH   = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  prbs_checker_if.slave  bus
);

  localparam int SEED_W  = $clog2(PRBS_N + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WBIT_W  = $clog2(WINDOW);
  localparam int WERR_W  = $clog2(UNLOCK_ERRS + 1);

  localparam logic [SEED_W-1:0]  SEED_LAST  = SEED_W'(PRBS_N - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [WBIT_W-1:0]  WBIT_LAST  = WBIT_W'(WINDOW - 1);
  localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(UNLOCK_ERRS - 1);

  CHK_STATE            state_q;
  prbs_t               lfsr_q;
  logic [SEED_W-1:0]   seed_q;
  logic [MATCH_W-1:0]  match_q;
  logic [WBIT_W-1:0]   wbit_q;
  logic [WERR_W-1:0]   werr_q;
  logic                locked_q;
  logic                err_q;

  logic  pred;
  logic  miss;
  prbs_t seed_shift;
  logic  bit_inc;
  logic  err_inc;

  assign pred       = prbs_pred(lfsr_q);
  assign miss       = bus.in ^ pred;
  assign seed_shift = {lfsr_q[PRBS_N-2:0], bus.in};
  assign bit_inc    = bus.cke && (state_q == CHK_LOCKED);
  assign err_inc    = bit_inc && miss;

  // Seed / verify / lock state machine with its LFSR, lock-qualify and window counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CHK_SEED;
      lfsr_q   <= '0;
      seed_q   <= '0;
      match_q  <= '0;
      wbit_q   <= '0;
      werr_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (bus.cke) begin
        case (state_q)
          CHK_SEED: begin
            lfsr_q <= seed_shift;
            if (seed_q == SEED_LAST) begin
              seed_q <= '0;
              // An all-zero seed would predict zeros forever, so stuck-at-0 reseeds.
              if (seed_shift != '0) begin
                state_q <= CHK_VERIFY;
                match_q <= '0;
              end
            end else begin
              seed_q <= seed_q + SEED_W'(1);
            end
          end
          CHK_VERIFY: begin
            // Free-run on the prediction so a single bad bit cannot corrupt the LFSR.
            lfsr_q <= prbs_next(lfsr_q);
            if (miss) begin
              state_q <= CHK_SEED;
              seed_q  <= '0;
              match_q <= '0;
            end else if (match_q == MATCH_LAST) begin
              state_q  <= CHK_LOCKED;
              locked_q <= 1'b1;
              match_q  <= '0;
            end else begin
              match_q <= match_q + MATCH_W'(1);
            end
          end
          CHK_LOCKED: begin
            lfsr_q <= prbs_next(lfsr_q);
            err_q  <= miss;
            if (miss && (werr_q == WERR_LAST)) begin
              // Too many errors this window: drop lock; window restarts on the next lock.
              state_q  <= CHK_SEED;
              locked_q <= 1'b0;
              seed_q   <= '0;
              wbit_q   <= '0;
              werr_q   <= '0;
            end else if (wbit_q == WBIT_LAST) begin
              wbit_q <= '0;
              werr_q <= '0;
            end else begin
              wbit_q <= wbit_q + WBIT_W'(1);
              werr_q <= werr_q + WERR_W'(miss);
            end
          end
          default: state_q <= CHK_SEED;
        endcase
      end
    end
  end

  sat_counter #(.WIDTH(BIT_WIDTH)) u_bit_count (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (bit_inc),
    .clr_i   (bus.clear),
    .count_o (bus.bit_count)
  );

  sat_counter #(.WIDTH(ERR_WIDTH)) u_err_count (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (err_inc),
    .clr_i   (bus.clear),
    .count_o (bus.err_count)
  );

  assign bus.locked = locked_q;
  assign bus.err    = err_q;

endmodule
